seq_detector_prog: RTL
======================

Name: seq_detector_prog

Overview:
- Runtime-programmable serial bit-sequence detector; successor to the team's fixed-pattern Moore detector.
- Pattern value and length (1..MAX_LEN) are loaded through a configuration strobe.
- Overlapping or non-overlapping detection is selectable.
- A saturating match counter is kept alongside the detector.
- Sits on a serial bit stream (framing/sync-word detection) and flags each match with a one-cycle registered pulse.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (>=2).
- CNT_W, 8: match counter width.
- LW, $clog2(MAX_LEN)+1: derived, not overridden; width of the length fields.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- x  in  1  serial data bit.
- x_valid  in  1  x is sampled on this cycle's rising edge only when high.
- pat_load  in  1  one-cycle strobe; latches pat_in and len_in.
- pat_in  in  MAX_LEN  pattern; bit len-1 is the first bit received, bit 0 the last.
- len_in  in  LW  pattern length; legal range 1..MAX_LEN.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cnt_clr  in  1  synchronous clear of match_cnt.
- z  out  1  registered match pulse.
- match_cnt  out  CNT_W  saturating count of matches.
- cfg_ok  out  1  a legal pattern is loaded.
- cfg_err  out  1  one-cycle pulse on an illegal load.

Behaviour:
- Reset (async, active-high):
  - state=UNCFG; history, fill count, pattern and length registers cleared.
  - z=0, match_cnt=0, cfg_ok=0, cfg_err=0.
- State machine (3 states):
  - UNCFG: x ignored.
  - FILL: fewer than len valid bits held since load or last non-overlap match.
  - HUNT: at least len bits held.
- pat_load with 1<=len_in<=MAX_LEN:
  - Latch pattern and length; clear history and fill count; go to FILL; cfg_ok=1.
  - z=0 on the following cycle.
- pat_load with len_in==0 or len_in>MAX_LEN:
  - cfg_err pulses one cycle; all other state is unchanged, including a previously loaded pattern.
- pat_load has priority over x_valid in the same cycle; that x bit is discarded.
- Valid bit (x_valid=1, no pat_load, state!=UNCFG):
  - hist <= {hist[MAX_LEN-2:0], x}.
  - fill increments, saturating at MAX_LEN.
  - FILL->HUNT when the new fill reaches len.
- Match condition: new fill>=len and new hist[len-1:0]==pat[len-1:0]; only the low len bits are compared.
- On a match:
  - z=1 in the cycle after the edge that sampled the final bit, for exactly one cycle.
  - z=0 on every other cycle, including cycles with x_valid=0.
  - match_cnt increments on the same edge z rises, saturating at 2^CNT_W-1 (no wrap).
  - overlap=1: history retained and the state stays HUNT.
  - overlap=0: fill cleared and the state returns to FILL; the matching bits cannot start a new match.
- overlap is sampled at the matching edge; changing it mid-stream affects only subsequent matches.
- cnt_clr:
  - Sets match_cnt=0 next cycle.
  - If a match occurs on the same edge, clear wins: count=0, z still pulses.
- x_valid=0 cycles are stalls: no shift, no fill change, z=0.
- len=1 is legal; it degenerates to per-bit compare, z follows each matching valid bit.
- Reset asserted mid-stream aborts immediately; the block must be reprogrammed via pat_load.

Optional Feature:
- Macro: SEQDET_MASK_EN.
- Defined:
  - Adds input mask_in[MAX_LEN-1:0], latched with pat_load.
  - Masked bits (mask=1) are don't-care in the compare.
  - An all-ones mask over len matches on every valid bit once fill>=len.
- Undefined: no mask port; an exact compare over len bits.

Test Plan:
- Reset then load pat=4'b1101, len=4, overlap=1; stream 1,1,0,1,1,0,1 (x_valid=1) -> z pulses after bits 4 and 7; match_cnt=2; cfg_ok=1.
- Same load, overlap=0, same stream -> z pulses after bit 4 only; match_cnt=1.
- Load len_in=0 (and len_in=MAX_LEN+1) after a valid 1101 load -> cfg_err one-cycle pulse; stream 1101 still matches with the old pattern.
- Stream 1,1,x_valid=0 for 3 cycles,0,1 -> no z during the stall; z pulses one cycle after the final 1; pat_load coincident with a valid bit -> that bit ignored, fill=0.
- CNT_W=2, 4 overlapping matches of pat=2'b11 (stream 1,1,1,1,1) -> match_cnt saturates at 3; cnt_clr on a matching cycle -> match_cnt=0, z=1.
- Assert reset mid-pattern (after 1,1,0) -> z=0, match_cnt=0, cfg_ok=0; further bits produce no z until pat_load.

Source files
------------

// File: rtl/seq_detector_prog.sv
// seq_detector_prog: runtime-programmable serial bit-sequence detector.
// A pattern of 1..MAX_LEN bits is loaded with pat_load. Each valid input bit
// is shifted into a history register, and a match raises a one-cycle
// registered pulse on z. Detection can overlap or not, and a saturating
// counter tracks the number of matches.
// Optional feature macro: SEQDET_MASK_EN. When it is defined, the module adds
// a mask_in port. Mask bits set to 1 are treated as don't-care in the compare.
module seq_detector_prog #(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LW      = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               x,
    input  logic               x_valid,
    input  logic               pat_load,
    input  logic [MAX_LEN-1:0] pat_in,
`ifdef SEQDET_MASK_EN
    input  logic [MAX_LEN-1:0] mask_in,
`endif
    input  logic [LW-1:0]      len_in,
    input  logic               overlap,
    input  logic               cnt_clr,
    output logic               z,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_ok,
    output logic               cfg_err
);

    typedef enum logic [1:0] {
        S_UNCFG,
        S_FILL,
        S_HUNT
    } state_e;

    state_e               state_q, state_d;
    // Only the newest MAX_LEN-1 bits are stored. Together with the incoming
    // bit, they form the full MAX_LEN-bit comparison window.
    logic [MAX_LEN-2:0]   hist_q,  hist_d;
    logic [LW-1:0]        fill_q,  fill_d;
    logic [MAX_LEN-1:0]   pat_q,   pat_d;
    logic [LW-1:0]        len_q,   len_d;
    logic                 z_q,     z_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic                 cfg_err_q, cfg_err_d;
`ifdef SEQDET_MASK_EN
    logic [MAX_LEN-1:0]   mask_q,  mask_d;
`endif

    logic                 len_legal;
    logic [MAX_LEN-1:0]   window;
    logic [MAX_LEN-1:0]   cmp_mask;
    logic [LW-1:0]        new_fill;
    logic                 match;

    assign len_legal = (len_in != '0) && (len_in <= LW'(MAX_LEN));
    assign window    = {hist_q, x};

    // Next-state logic: configuration load, bit shifting, match detection and counting.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves a value held and no latch is inferred.
        state_d   = state_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        pat_d     = pat_q;
        len_d     = len_q;
        z_d       = 1'b0;
        cnt_d     = cnt_q;
        cfg_err_d = 1'b0;
`ifdef SEQDET_MASK_EN
        mask_d    = mask_q;
`endif
        cmp_mask  = '0;
        new_fill  = (fill_q == LW'(MAX_LEN)) ? fill_q : fill_q + LW'(1);
        match     = 1'b0;

        for (int i = 0; i < MAX_LEN; i++) begin
            cmp_mask[i] = (LW'(i) < len_q);
        end
`ifdef SEQDET_MASK_EN
        cmp_mask = cmp_mask & ~mask_q;
`endif

        if (pat_load) begin
            // A load takes priority over any bit presented in the same cycle, and that bit is dropped.
            if (len_legal) begin
                pat_d   = pat_in;
                len_d   = len_in;
                hist_d  = '0;
                fill_d  = '0;
                state_d = S_FILL;
`ifdef SEQDET_MASK_EN
                mask_d  = mask_in;
`endif
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (x_valid && state_q != S_UNCFG) begin
            hist_d  = window[MAX_LEN-2:0];
            fill_d  = new_fill;
            state_d = (new_fill >= len_q) ? S_HUNT : S_FILL;
            match   = (new_fill >= len_q) && (((window ^ pat_q) & cmp_mask) == '0);
            if (match) begin
                z_d = 1'b1;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (!overlap) begin
                    fill_d  = '0;
                    state_d = S_FILL;
                end
            end
        end

        // A clear overrides an increment on the same edge.
        if (cnt_clr) begin
            cnt_d = '0;
        end
    end

    // State and datapath registers, all cleared on asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_UNCFG;
            hist_q    <= '0;
            fill_q    <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            z_q       <= 1'b0;
            cnt_q     <= '0;
            cfg_err_q <= 1'b0;
`ifdef SEQDET_MASK_EN
            mask_q    <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments, so every register samples its pre-edge value.
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            z_q       <= z_d;
            cnt_q     <= cnt_d;
            cfg_err_q <= cfg_err_d;
`ifdef SEQDET_MASK_EN
            mask_q    <= mask_d;
`endif
        end
    end

    assign z         = z_q;
    assign match_cnt = cnt_q;
    assign cfg_err   = cfg_err_q;
    assign cfg_ok    = (state_q != S_UNCFG);

endmodule
